mem_nport_clr: RTL and testbench

Parametrised N-read-port, single-write-port synchronous memory with per-byte write enables, write-first read-during-write forwarding, and a built-in sequential fast-clear engine. It is the successor to the fixed two-read 64K×32 store used by the triangle pipeline. It serves as the team's generic framebuffer/z-buffer and vertex/attribute store, and adds the ability to fill the whole array with a constant between frames without an external write loop.

---
 rtl/mem_nport_clr.sv | 126 ++++++++++++
 tb/tb_mem_nport_clr.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_nport_clr.sv
// rtl/mem_nport_clr.sv - N-read, 1-write byte-enabled memory with write-first forwarding and fast clear
module mem_nport_clr #(
  parameter int DW    = 32,
  parameter int AW    = 16,
  parameter int DEPTH = 2**AW,
  parameter int NRD   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_valid,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [DW/8-1:0]   wr_be,
  output logic              wr_ready,
  input  logic              clr_start,
  input  logic [DW-1:0]     clr_value,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int NB = DW/8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [DW-1:0]   clr_val;
  logic [DW-1:0]   mem [DEPTH];

  logic            we;
  logic [AW-1:0]   wa;
  logic [DW-1:0]   wd;
  logic [NB-1:0]   wbe;
  logic [DW-1:0]   rd_next [NRD];

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(DEPTH);
  endfunction

  assign wr_ready = (state == IDLE);

  // The clear engine owns the single write port while it runs.
  always_comb begin
    we  = 1'b0;
    wa  = wr_addr;
    wd  = wr_data;
    wbe = wr_be;
    if (state == CLEAR) begin
      we  = 1'b1;
      wa  = ptr;
      wd  = clr_val;
      wbe = '1;
    end else if (wr_en && in_range(wr_addr) && (wr_be != '0)) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem[wa][b*8 +: 8] <= wd[b*8 +: 8];
      end
    end
  end

  // Write-first: enabled bytes of a same-address write override the array word.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_next[i] = '0;
      if (in_range(rd_addr[i*AW +: AW])) begin
        rd_next[i] = mem[rd_addr[i*AW +: AW]];
        if (we && (wa == rd_addr[i*AW +: AW])) begin
          for (int b = 0; b < NB; b++) begin
            if (wbe[b]) rd_next[i][b*8 +: 8] = wd[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_en;
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) rd_data[i*DW +: DW] <= rd_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_val  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            clr_val  <= clr_value;
            ptr      <= '0;
            state    <= CLEAR;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == AW'(DEPTH-1)) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_nport_clr.sv
// tb/tb_mem_nport_clr.sv - scoreboard bench for mem_nport_clr (DEPTH=16 and DEPTH=12 instances)
module tb_mem_nport_clr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  m_rd_en = '0;
  logic [7:0]  m_rd_addr = '0;
  logic [63:0] m_rd_data;
  logic [1:0]  m_rd_valid;
  logic        m_wr_en = 1'b0;
  logic [3:0]  m_wr_addr = '0;
  logic [31:0] m_wr_data = '0;
  logic [3:0]  m_wr_be = '0;
  logic        m_wr_ready;
  logic        m_clr_start = 1'b0;
  logic [31:0] m_clr_value = '0;
  logic        m_clr_busy;
  logic        m_clr_done;

  logic [1:0]  o_rd_en = '0;
  logic [7:0]  o_rd_addr = '0;
  logic [63:0] o_rd_data;
  logic [1:0]  o_rd_valid;
  logic        o_wr_en = 1'b0;
  logic [3:0]  o_wr_addr = '0;
  logic [31:0] o_wr_data = '0;
  logic [3:0]  o_wr_be = 4'hf;
  logic        o_wr_ready;
  logic        o_clr_start = 1'b0;
  logic [31:0] o_clr_value = '0;
  logic        o_clr_busy;
  logic        o_clr_done;

  mem_nport_clr #(.DW(32), .AW(4), .DEPTH(16), .NRD(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_en(m_rd_en), .rd_addr(m_rd_addr), .rd_data(m_rd_data),
    .rd_valid(m_rd_valid), .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_data(m_wr_data),
    .wr_be(m_wr_be), .wr_ready(m_wr_ready), .clr_start(m_clr_start), .clr_value(m_clr_value),
    .clr_busy(m_clr_busy), .clr_done(m_clr_done));

  mem_nport_clr #(.DW(32), .AW(4), .DEPTH(12), .NRD(2)) u_oor (
    .clk(clk), .rst_n(rst_n), .rd_en(o_rd_en), .rd_addr(o_rd_addr), .rd_data(o_rd_data),
    .rd_valid(o_rd_valid), .wr_en(o_wr_en), .wr_addr(o_wr_addr), .wr_data(o_wr_data),
    .wr_be(o_wr_be), .wr_ready(o_wr_ready), .clr_start(o_clr_start), .clr_value(o_clr_value),
    .clr_busy(o_clr_busy), .clr_done(o_clr_done));

  int n_vec = 0;
  int n_miss = 0;
  int busy_cnt = 0;
  logic [31:0] mq0[$], mq1[$], oq0[$], oq1[$];
  int dq[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic extra(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: output with no expected entry", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m_rd_en = '0; m_wr_en = 1'b0; m_clr_start = 1'b0;
    o_rd_en = '0; o_wr_en = 1'b0;
  endtask

  task automatic mrd(input int p, input logic [3:0] a, input logic [31:0] e);
    m_rd_en[p] = 1'b1;
    m_rd_addr[p*4 +: 4] = a;
    if (p == 0) mq0.push_back(e); else mq1.push_back(e);
  endtask

  task automatic mwr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    m_wr_en = 1'b1; m_wr_addr = a; m_wr_data = d; m_wr_be = be;
  endtask

  task automatic ord(input int p, input logic [3:0] a, input logic [31:0] e);
    o_rd_en[p] = 1'b1;
    o_rd_addr[p*4 +: 4] = a;
    if (p == 0) oq0.push_back(e); else oq1.push_back(e);
  endtask

  task automatic owr(input logic [3:0] a, input logic [31:0] d);
    o_wr_en = 1'b1; o_wr_addr = a; o_wr_data = d;
  endtask

  function automatic logic [31:0] after_rst(input int k);
    return (k < 6) ? 32'hA5A5A5A5 : 32'h10000000 + k;
  endfunction

  // Monitor: pops expected read data per port and expected clear length per clr_done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_rd_valid[0]) begin
        if (mq0.size() == 0) extra("m_port0"); else cmp("m_port0 data", m_rd_data[31:0], mq0.pop_front());
      end
      if (m_rd_valid[1]) begin
        if (mq1.size() == 0) extra("m_port1"); else cmp("m_port1 data", m_rd_data[63:32], mq1.pop_front());
      end
      if (o_rd_valid[0]) begin
        if (oq0.size() == 0) extra("o_port0"); else cmp("o_port0 data", o_rd_data[31:0], oq0.pop_front());
      end
      if (o_rd_valid[1]) begin
        if (oq1.size() == 0) extra("o_port1"); else cmp("o_port1 data", o_rd_data[63:32], oq1.pop_front());
      end
      if (m_clr_done) begin
        if (dq.size() == 0) extra("clr_done");
        else cmp("clr busy cycles", 64'(busy_cnt), 64'(dq.pop_front()));
        cmp("wr_ready at done", 64'(m_wr_ready), 64'd1);
        busy_cnt = 0;
      end else if (m_clr_busy) begin
        busy_cnt++;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp("reset rd_data", m_rd_data, 64'd0);
    cmp("reset rd_valid", 64'(m_rd_valid), 64'd0);
    cmp("reset busy/done/ready", {61'd0, m_clr_busy, m_clr_done, m_wr_ready}, 64'd1);
    rst_n = 1'b1;
    step();

    mwr(4'd10, 32'hDEADBEEF, 4'hf); step();
    mrd(0, 4'd10, 32'hDEADBEEF); mrd(1, 4'd10, 32'hDEADBEEF); step();
    cmp("dual rd_valid", 64'(m_rd_valid), 64'd3);

    mwr(4'd5, 32'h11223344, 4'hf); step();
    mwr(4'd5, 32'hAABBCCDD, 4'b0101); mrd(0, 4'd5, 32'h11BB33DD); step();
    mrd(1, 4'd5, 32'h11BB33DD); step();
    step();
    cmp("rd_data hold", 64'(m_rd_data[31:0]), 64'h11BB33DD);
    mwr(4'd5, 32'h0, 4'h0); step();
    mrd(0, 4'd5, 32'h11BB33DD); step();

    m_clr_start = 1'b1; m_clr_value = 32'hFFFFFFFF; dq.push_back(16);
    mwr(4'd7, 32'h12345678, 4'hf);
    step();
    cmp("wr_ready in clear", 64'(m_wr_ready), 64'd0);
    cmp("clr_busy in clear", 64'(m_clr_busy), 64'd1);
    step(); step();
    mwr(4'd0, 32'h0, 4'hf); step();
    mrd(0, 4'd3, 32'hFFFFFFFF); m_clr_start = 1'b1; m_clr_value = 32'h0; step();
    for (int i = 0; i < 40 && m_clr_busy; i++) step();
    cmp("clear finished", 64'(m_clr_busy), 64'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      mrd(0, 4'(2*i), 32'hFFFFFFFF); mrd(1, 4'(2*i+1), 32'hFFFFFFFF); step();
    end

    for (int i = 0; i < 16; i++) begin
      mwr(4'(i), 32'h10000000 + i, 4'hf); step();
    end
    m_clr_start = 1'b1; m_clr_value = 32'hA5A5A5A5; step();
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    cmp("midclr reset rd_valid", 64'(m_rd_valid), 64'd0);
    cmp("midclr reset busy/done/ready", {61'd0, m_clr_busy, m_clr_done, m_wr_ready}, 64'd1);
    step(); step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      mrd(0, 4'(2*i), after_rst(2*i)); mrd(1, 4'(2*i+1), after_rst(2*i+1)); step();
    end

    owr(4'd11, 32'hCAFEF00D); step();
    owr(4'd13, 32'h13131313); step();
    ord(0, 4'd13, 32'h0); ord(1, 4'd11, 32'hCAFEF00D); step();
    cmp("oor rd_valid", 64'(o_rd_valid), 64'd3);
    ord(0, 4'd12, 32'h0); ord(1, 4'd11, 32'hCAFEF00D); step();
    step(); step();

    cmp("m_port0 pending", 64'(mq0.size()), 64'd0);
    cmp("m_port1 pending", 64'(mq1.size()), 64'd0);
    cmp("o_ports pending", 64'(oq0.size() + oq1.size()), 64'd0);
    cmp("clr_done pending", 64'(dq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
